// File: rtl/segment_scan_reader.sv
// Samples a multiplexed active-low 7-segment/anode scan bus, debounces each digit dwell,
// decodes glyphs to hex nibbles and publishes a complete 4-digit frame with a Valid pulse.
module segment_scan_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [3:0]  AnIn,
  input  logic [6:0]  SegIn,
  output logic [15:0] Value,
  output logic [3:0]  ErrMask,
  output logic        Valid
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
  function automatic logic [4:0] decodeGlyph(input logic [6:0] seg);
    case (seg)
      7'h40:   decodeGlyph = 5'h00;
      7'h79:   decodeGlyph = 5'h01;
      7'h24:   decodeGlyph = 5'h02;
      7'h30:   decodeGlyph = 5'h03;
      7'h19:   decodeGlyph = 5'h04;
      7'h12:   decodeGlyph = 5'h05;
      7'h02:   decodeGlyph = 5'h06;
      7'h78:   decodeGlyph = 5'h07;
      7'h00:   decodeGlyph = 5'h08;
      7'h10:   decodeGlyph = 5'h09;
      7'h08:   decodeGlyph = 5'h0A;
      7'h03:   decodeGlyph = 5'h0B;
      7'h46:   decodeGlyph = 5'h0C;
      7'h21:   decodeGlyph = 5'h0D;
      7'h06:   decodeGlyph = 5'h0E;
      7'h0E:   decodeGlyph = 5'h0F;
      default: decodeGlyph = 5'h10;
    endcase
  endfunction

  function automatic logic [2:0] digitSelect(input logic [3:0] an);
    case (an)
      4'b1110: digitSelect = 3'b100;
      4'b1101: digitSelect = 3'b101;
      4'b1011: digitSelect = 3'b110;
      4'b0111: digitSelect = 3'b111;
      default: digitSelect = 3'b000;
    endcase
  endfunction

  logic [3:0]  anQ_r, anPrev_r, pendErr_r, seen_r;
  logic [6:0]  segQ_r, segPrev_r;
  logic [7:0]  stableCnt_r;
  logic [15:0] slots_r;

  logic        selecting_s, same_s, capture_s, flush_s;
  logic [2:0]  digitSel_s;
  logic [4:0]  glyph_s;
  logic [7:0]  cntNext_s;
  logic [3:0]  capMask_s, seenNext_s, errNext_s;
  logic [15:0] slotsNext_s;

  assign digitSel_s  = digitSelect(anQ_r);
  assign selecting_s = digitSel_s[2];
  assign same_s      = ({anQ_r, segQ_r} == {anPrev_r, segPrev_r});
  assign glyph_s     = decodeGlyph(segQ_r);
  assign flush_s     = (seen_r == 4'b1111);

  // Dwell counter: reload on change, clear on idle, saturate at the threshold.
  always_comb begin
    cntNext_s = 8'd0;
    if (!selecting_s) begin
      cntNext_s = 8'd0;
    end else if (!same_s) begin
      cntNext_s = 8'd1;
    end else if (stableCnt_r >= CNT_MAX) begin
      cntNext_s = CNT_MAX;
    end else begin
      cntNext_s = stableCnt_r + 8'd1;
    end
  end

  // Capture bookkeeping; a capture on the flush cycle starts the next frame.
  always_comb begin
    capture_s   = selecting_s && (cntNext_s == CNT_MAX) && (stableCnt_r != CNT_MAX);
    capMask_s   = capture_s ? (4'b0001 << digitSel_s[1:0]) : 4'b0000;
    seenNext_s  = (flush_s ? 4'b0000 : seen_r) | capMask_s;
    errNext_s   = ((flush_s ? 4'b0000 : pendErr_r) & ~capMask_s)
                | (glyph_s[4] ? capMask_s : 4'b0000);
    slotsNext_s = slots_r;
    for (int k = 0; k < 4; k++) begin
      if (capMask_s[k]) begin
        slotsNext_s[4*k +: 4] = glyph_s[3:0];
      end else begin
        slotsNext_s[4*k +: 4] = slots_r[4*k +: 4];
      end
    end
  end

  // All state, including the registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      anQ_r       <= 4'h0;
      segQ_r      <= 7'h00;
      anPrev_r    <= 4'h0;
      segPrev_r   <= 7'h00;
      stableCnt_r <= 8'd0;
      slots_r     <= 16'h0000;
      pendErr_r   <= 4'h0;
      seen_r      <= 4'h0;
      Value       <= 16'h0000;
      ErrMask     <= 4'h0;
      Valid       <= 1'b0;
    end else begin
      anQ_r       <= AnIn;
      segQ_r      <= SegIn;
      anPrev_r    <= anQ_r;
      segPrev_r   <= segQ_r;
      stableCnt_r <= cntNext_s;
      slots_r     <= slotsNext_s;
      pendErr_r   <= errNext_s;
      seen_r      <= seenNext_s;
      Value       <= flush_s ? slots_r : Value;
      ErrMask     <= flush_s ? pendErr_r : ErrMask;
      Valid       <= flush_s;
    end
  end

endmodule

// File: doc/segment_scan_reader.md
SEGMENT_SCAN_READER -- requirements
Module: segment_scan_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive identical samples required before a digit is captured (legal range 2..255).
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 AnIn  input  4  SHALL be the digit select, active-low (bit k low = digit k driven).
REQ-005 SegIn  input  7  SHALL be the segments {g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-006 Value  output  16  SHALL carry the last complete frame; digit k in Value[4k+3:4k].
REQ-007 ErrMask  output  4  SHALL flag digits of the last frame whose pattern was not a legal glyph.
REQ-008 Valid  output  1  SHALL be a one-cycle pulse marking a new Value/ErrMask.

Function
REQ-009 AnIn and SegIn SHALL be registered once before any use; all latencies count from this register.
REQ-010 A sample SHALL be "selecting" only when exactly one AnIn bit is low; 4'b1111, 4'b0000 and multi-low patterns are idle.
REQ-011 A stability counter SHALL increment while the registered {AnIn,SegIn} equals the previous sample and is selecting; it SHALL reload to 1 on any change and to 0 on idle.
REQ-012 Capture SHALL occur once per dwell, on the cycle the counter reaches STABLE_CYCLES; no further capture until {AnIn,SegIn} changes, and the counter SHALL saturate.
REQ-013 Decode (SegIn hex, 0..F): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E map to nibble 0..F.
REQ-014 Any other SegIn SHALL capture nibble 0 and set that digit's pending error bit.
REQ-015 Capture SHALL write the nibble to a pending slot and set that digit's bit in a 4-bit seen mask; recapturing a seen digit SHALL overwrite slot and error bit.
REQ-016 When a capture makes the seen mask 4'b1111, the next cycle SHALL load Value and ErrMask from the pending slots, assert Valid for exactly one cycle, and clear the seen mask and pending errors.
REQ-017 Value and ErrMask SHALL hold between Valid pulses; a partial frame never updates them.
REQ-018 Digit order within a frame SHALL be irrelevant; dwell-to-dwell glitches shorter than STABLE_CYCLES SHALL be ignored.
REQ-019 Worst-case latency, last digit stable to Valid: 1 (input reg) + STABLE_CYCLES + 1 cycles.

Reset
REQ-020 While Rst_n is low at a clock edge: Value = 16'h0000, ErrMask = 4'h0, Valid = 0, seen mask, pending slots, counter and input registers cleared.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame; the first post-reset frame needs all four digits.
REQ-022 Reset SHALL override a capture or Valid in the same cycle.

Verification
REQ-023 Scan digits 0..3 with 5,A,0,3 (SegIn 12,08,40,30), 8 cycles each -> one Valid pulse, Value = 16'h30A5, ErrMask = 0.
REQ-024 Dwell of STABLE_CYCLES-1 cycles on digit 2 inside a frame -> no capture, no Valid until digit 2 is redriven stably.
REQ-025 Digit 1 SegIn = 7F (blank) in a full frame of 1s -> Value = 16'h1101, ErrMask = 4'b0010, Valid pulses once.
REQ-026 AnIn = 0000 or 0011 held 20 cycles -> no capture; counter stays 0; outputs unchanged.
REQ-027 Pull Rst_n low for 1 cycle after three digits captured, then scan four digits of 9 -> exactly one Valid, Value = 16'h9999.
REQ-028 Continuous 4-digit scan with STABLE_CYCLES = 2, 2-cycle dwells -> one Valid per scan period, no missed or duplicate frames.
